// File: rtl/decode_3_8_pkg.sv
// ----------------------------------------------------------------------------
// decode_3_8_pkg
// Shared types and constants for the registered 3-to-8 decoder family.
//   - state encoding for the decode/sweep FSM
//   - bus widths
//   - active-high 7-segment glyph table for digits 0..7 and the blank value
//   - helper producing a one-hot LED vector from a binary code
// ----------------------------------------------------------------------------
package decode_3_8_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned LED_W  = 8;
    localparam int unsigned SEG_W  = 8;
    localparam int unsigned ST_W   = 2;

    // FSM state encoding
    typedef enum logic [ST_W-1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_SWEEP = 2'd2
    } state_e;

    // Plain-vector aliases of the state encoding for the state register
    localparam logic [ST_W-1:0] ST_IDLE  = S_IDLE;
    localparam logic [ST_W-1:0] ST_SHOW  = S_SHOW;
    localparam logic [ST_W-1:0] ST_SWEEP = S_SWEEP;

    // Active-high glyphs, bit0=a .. bit6=g, bit7=dp; entry n is digit n
    localparam logic [7:0][SEG_W-1:0] SEG_PAT = {
        8'h07,  // 7
        8'h7D,  // 6
        8'h6D,  // 5
        8'h66,  // 4
        8'h4F,  // 3
        8'h5B,  // 2
        8'h06,  // 1
        8'h3F   // 0
    };

    // Active-low display with every segment and the dp dark
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

    // One-hot LED vector with bit n set for code n
    function automatic logic [LED_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
        logic [LED_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage : decode_3_8_pkg

// File: rtl/decode_3_8_seq_if.sv
// ----------------------------------------------------------------------------
// decode_3_8_seq_if
// Request/display bundle of the registered 3-to-8 decoder.
//   en        block enable; low forces idle
//   mode      0 = decode, 1 = sweep
//   in_valid  qualifies code in decode mode
//   code      binary code to decode
//   out_valid onehot/seg currently show a code
//   onehot    one-hot LED vector, zero when idle
//   seg       active-low 7-segment digit, dp always dark
// master: the side issuing codes; slave: the decoder.
// ----------------------------------------------------------------------------
interface decode_3_8_seq_if;
    import decode_3_8_pkg::*;

    logic              en;
    logic              mode;
    logic              in_valid;
    logic [CODE_W-1:0] code;
    logic              out_valid;
    logic [LED_W-1:0]  onehot;
    logic [SEG_W-1:0]  seg;

    modport master (
        output en,
        output mode,
        output in_valid,
        output code,
        input  out_valid,
        input  onehot,
        input  seg
    );

    modport slave (
        input  en,
        input  mode,
        input  in_valid,
        input  code,
        output out_valid,
        output onehot,
        output seg
    );

endinterface : decode_3_8_seq_if

// File: rtl/seg7_digit.sv
// ----------------------------------------------------------------------------
// seg7_digit
// Combinational 3-bit code to active-low 7-segment digit.
//   code  [2:0]  digit to show (0..7)
//   en           1 = show the digit, 0 = blank
//   seg   [7:0]  active-low segments, seg[0]=a .. seg[6]=g, seg[7]=dp (dark)
// ----------------------------------------------------------------------------
module seg7_digit
    import decode_3_8_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              en,
    output logic [SEG_W-1:0]  seg
);

    // Glyph table is active-high with dp clear, so inversion also darkens dp
    always_comb begin
        seg = SEG_BLANK;
        if (en) begin
            seg = ~SEG_PAT[code];
        end
    end

endmodule : seg7_digit

// File: rtl/decode_3_8_seq.sv
// ----------------------------------------------------------------------------
// decode_3_8_seq
// Registered 3-to-8 decoder with hold stretcher and LED sweep self-test.
//   clk      clock, all state changes on posedge
//   rst_n    synchronous active-low reset
//   bus      decode_3_8_seq_if.slave:
//              en, mode, in_valid, code         (inputs)
//              out_valid, onehot (registered), seg (from registered state)
// Parameters:
//   HOLD_CYCLES  extra cycles a code stays shown after in_valid drops
//   SWEEP_DIV    clk cycles per sweep step (>= 1)
// ----------------------------------------------------------------------------
module decode_3_8_seq
    import decode_3_8_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 3,
    parameter int unsigned SWEEP_DIV   = 25_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    decode_3_8_seq_if.slave  bus
);

    // Counter widths, each at least one bit so HOLD_CYCLES=0 / SWEEP_DIV=1 stay legal
    localparam int unsigned HOLD_W = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DIV_W  = (SWEEP_DIV <= 1)   ? 1 : $clog2(SWEEP_DIV);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SWEEP_DIV - 1);

    logic [ST_W-1:0]   state_q,    state_d;
    logic [CODE_W-1:0] cur_code_q, cur_code_d;
    logic              valid_q,    valid_d;
    logic [LED_W-1:0]  onehot_q,   onehot_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
    logic [SEG_W-1:0]  seg_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cur_code_q <= '0;
            valid_q    <= 1'b0;
            onehot_q   <= '0;
            hold_cnt_q <= '0;
            div_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_code_q <= cur_code_d;
            valid_q    <= valid_d;
            onehot_q   <= onehot_d;
            hold_cnt_q <= hold_cnt_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

    // Next-state and next-output logic; priority en=0 > sweep > decode
    always_comb begin
        state_d    = state_q;
        cur_code_d = cur_code_q;
        valid_d    = valid_q;
        hold_cnt_d = hold_cnt_q;
        div_cnt_d  = div_cnt_q;

        if (!bus.en) begin
            state_d    = ST_IDLE;
            cur_code_d = '0;
            valid_d    = 1'b0;
            hold_cnt_d = '0;
            div_cnt_d  = '0;
        end else if (bus.mode) begin
            if (state_q != ST_SWEEP) begin
                // Entry abandons any pending hold and restarts at LED 0
                state_d    = ST_SWEEP;
                cur_code_d = '0;
                valid_d    = 1'b1;
                hold_cnt_d = '0;
                div_cnt_d  = '0;
            end else if (div_cnt_q == DIV_LAST) begin
                div_cnt_d  = '0;
                cur_code_d = CODE_W'(cur_code_q + 1'b1);
            end else begin
                div_cnt_d  = DIV_W'(div_cnt_q + 1'b1);
            end
        end else if (bus.in_valid) begin
            // code is only sampled when qualified, so X on it cannot leak
            state_d    = ST_SHOW;
            cur_code_d = bus.code;
            valid_d    = 1'b1;
            hold_cnt_d = HOLD_LOAD;
        end else begin
            case (state_q)
                ST_SHOW: begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = HOLD_W'(hold_cnt_q - 1'b1);
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                end
                ST_SWEEP: begin
                    state_d   = ST_IDLE;
                    valid_d   = 1'b0;
                    div_cnt_d = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end

        onehot_d = valid_d ? onehot_of(cur_code_d) : '0;
    end

    seg7_digit u_seg7_digit (
        .code (cur_code_q),
        .en   (valid_q),
        .seg  (seg_c)
    );

    assign bus.out_valid = valid_q;
    assign bus.onehot    = onehot_q;
    assign bus.seg       = seg_c;

endmodule : decode_3_8_seq

// File: tb/tb_decode_3_8_seq.sv
// ----------------------------------------------------------------------------
// tb_decode_3_8_seq
// Directed bench for decode_3_8_seq (HOLD_CYCLES=2, SWEEP_DIV=4). Each step
// drives inputs before a rising edge and queues the outputs expected after
// that edge; a monitor pops and compares after every edge.
// ----------------------------------------------------------------------------
module tb_decode_3_8_seq;

    typedef struct packed {
        logic       ov;
        logic [7:0] oh;
        logic [7:0] seg;
    } exp_t;

    logic clk;
    logic rst_n;

    decode_3_8_seq_if bus ();

    decode_3_8_seq #(
        .HOLD_CYCLES (2),
        .SWEEP_DIV   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q [$];
    string tag_q [$];
    int    n_vec  = 0;
    int    n_miss = 0;

    // Active-low digits 0..7, worked out by hand from the segment map
    logic [7:0] seg_tbl [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    // Drive one cycle of stimulus and queue the result expected after the edge
    task automatic step(input logic r, input logic e, input logic m, input logic v,
                        input logic [2:0] c, input logic xov, input logic [7:0] xoh,
                        input logic [7:0] xseg, input string tag);
        exp_t x;
        @(negedge clk);
        rst_n        = r;
        bus.en       = e;
        bus.mode     = m;
        bus.in_valid = v;
        bus.code     = c;
        x.ov  = xov;
        x.oh  = xoh;
        x.seg = xseg;
        exp_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    // Monitor: compare after every rising edge that has a queued expectation
    initial begin
        exp_t  x;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                t = tag_q.pop_front();
                n_vec++;
                if (bus.out_valid !== x.ov || bus.onehot !== x.oh || bus.seg !== x.seg) begin
                    n_miss++;
                    $display("FAIL %s: got out_valid=%b onehot=%02h seg=%02h, want out_valid=%b onehot=%02h seg=%02h",
                             t, bus.out_valid, bus.onehot, bus.seg, x.ov, x.oh, x.seg);
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.mode     = 1'b0;
        bus.in_valid = 1'b1;
        bus.code     = 3'd5;

        // 1. reset dominates a valid code, then code 5 appears one cycle later
        step(0, 1, 0, 1, 3'd5, 0, 8'h00, 8'hFF, "reset0");
        step(0, 1, 0, 1, 3'd5, 0, 8'h00, 8'hFF, "reset1");
        step(1, 1, 0, 1, 3'd5, 1, 8'h20, 8'h92, "post_reset");
        step(1, 1, 0, 0, 3'd0, 1, 8'h20, 8'h92, "post_reset_hold1");
        step(1, 1, 0, 0, 3'd0, 1, 8'h20, 8'h92, "post_reset_hold2");
        step(1, 1, 0, 0, 3'd0, 0, 8'h00, 8'hFF, "post_reset_idle");

        // 2. single pulse shows for 1+HOLD cycles
        step(1, 1, 0, 1, 3'd3, 1, 8'h08, 8'hB0, "pulse");
        step(1, 1, 0, 0, 3'd0, 1, 8'h08, 8'hB0, "pulse_hold1");
        step(1, 1, 0, 0, 3'd0, 1, 8'h08, 8'hB0, "pulse_hold2");
        step(1, 1, 0, 0, 3'd0, 0, 8'h00, 8'hFF, "pulse_end");
        // X on an unqualified code stays invisible
        step(1, 1, 0, 0, 3'bxxx, 0, 8'h00, 8'hFF, "idle_xcode");

        // 3. retrigger replaces code and restarts the hold
        step(1, 1, 0, 1, 3'd1, 1, 8'h02, 8'hF9, "retrig_a");
        step(1, 1, 0, 0, 3'bxxx, 1, 8'h02, 8'hF9, "retrig_a_hold");
        step(1, 1, 0, 1, 3'd6, 1, 8'h40, 8'h82, "retrig_b");
        step(1, 1, 0, 0, 3'd0, 1, 8'h40, 8'h82, "retrig_b_hold1");
        step(1, 1, 0, 0, 3'd0, 1, 8'h40, 8'h82, "retrig_b_hold2");
        step(1, 1, 0, 0, 3'd0, 0, 8'h00, 8'hFF, "retrig_end");

        // 4. sweep: each LED for 4 cycles, wrap 7->0, run on until LED 4
        for (int i = 0; i <= 48; i++) begin
            int k;
            k = (i / 4) % 8;
            step(1, 1, 1, i[0], 3'(i), 1, 8'(8'h01 << k), seg_tbl[k], $sformatf("sweep%0d", i));
        end

        // 5. enable drop clears, re-enable restarts the sweep at LED 0
        step(1, 0, 1, 0, 3'd0, 0, 8'h00, 8'hFF, "en_drop");
        step(1, 1, 1, 0, 3'd0, 1, 8'h01, 8'hC0, "resweep0");
        step(1, 1, 1, 0, 3'd0, 1, 8'h01, 8'hC0, "resweep1");
        step(1, 1, 1, 0, 3'd0, 1, 8'h01, 8'hC0, "resweep2");
        step(1, 1, 1, 0, 3'd0, 1, 8'h01, 8'hC0, "resweep3");
        step(1, 1, 1, 0, 3'd0, 1, 8'h02, 8'hF9, "resweep4");

        // 6. leaving sweep with a valid code goes straight to SHOW
        step(1, 1, 0, 1, 3'd7, 1, 8'h80, 8'hF8, "mode_exit_valid");
        step(1, 1, 0, 0, 3'd0, 1, 8'h80, 8'hF8, "mode_exit_hold1");
        step(1, 1, 0, 0, 3'd0, 1, 8'h80, 8'hF8, "mode_exit_hold2");
        step(1, 1, 0, 0, 3'd0, 0, 8'h00, 8'hFF, "mode_exit_end");

        // leaving sweep without a valid code goes idle at once
        step(1, 1, 1, 0, 3'd0, 1, 8'h01, 8'hC0, "sweep_enter");
        step(1, 1, 0, 0, 3'd4, 0, 8'h00, 8'hFF, "sweep_exit_idle");

        // sweep request during SHOW abandons the hold
        step(1, 1, 0, 1, 3'd2, 1, 8'h04, 8'hA4, "show_then_sweep");
        step(1, 1, 1, 1, 3'd6, 1, 8'h01, 8'hC0, "sweep_preempt");

        // enable drop during SHOW clears immediately
        step(1, 1, 0, 1, 3'd4, 1, 8'h10, 8'h99, "show4");
        step(1, 0, 0, 1, 3'd4, 0, 8'h00, 8'hFF, "show_en_drop");

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_decode_3_8_seq

// File: doc/decode_3_8_seq.md
Name: decode_3_8_seq

Overview:
- Registered 3-to-8 decoder: the receive-side counterpart of the board's 8-3 priority encoder.
- Takes a {valid, 3-bit code} pair and drives a one-hot 8-bit LED vector plus an active-low 7-segment digit showing the code.
- A hold stretcher keeps short pulses visible on the LEDs.
- A sweep mode walks a single lit LED for board self-test.

Parameters:
- HOLD_CYCLES, 3: extra cycles the output is held after in_valid drops (0 = no stretch).
- SWEEP_DIV, 25_000_000: clk cycles per sweep step (must be >= 1).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst_n  input  1  reset: synchronous, active-low.
- en  input  1  block enable; low forces idle.
- mode  input  1  0 = decode, 1 = sweep.
- in_valid  input  1  code qualifier (decode mode only).
- code  input  3  binary code to decode.
- out_valid  output  1  onehot/seg currently show a code.
- onehot  output  8  one-hot decode, bit n set for code n; 0 when idle.
- seg  output  8  active-low segments; seg[0]=a..seg[6]=g, seg[7]=dp (always off = 1).

Behaviour:
- States: IDLE, SHOW, SWEEP.
- Internal registers: cur_code[2:0], hold_cnt (width clog2(HOLD_CYCLES+1)), div_cnt (width clog2(SWEEP_DIV), min 1).
- Reset (rst_n=0 at a posedge): state=IDLE, out_valid=0, onehot=8'h00, cur_code=0, hold_cnt=0, div_cnt=0.
- Priority each cycle: rst_n > en=0 > mode=1 > decode logic.
  - en=0: next cycle same values as reset.
- onehot is registered: onehot = out_valid ? (8'h01 << cur_code) : 8'h00.
- seg is combinational from registered cur_code/out_valid, so it carries no extra latency.
  - out_valid=0: seg=8'hFF.
  - out_valid=1, codes 0..7: C0, F9, A4, B0, 99, 92, 82, F8.
- Decode mode (en=1, mode=0):
  - in_valid=1 in any state: next cycle state=SHOW, cur_code=code, out_valid=1, hold_cnt=HOLD_CYCLES. Latency is 1 cycle.
  - A new valid code during SHOW replaces cur_code and reloads hold_cnt.
  - SHOW with in_valid=0 and hold_cnt>0: hold_cnt decrements, outputs unchanged.
  - SHOW with in_valid=0 and hold_cnt=0: next cycle IDLE, out_valid=0, onehot=0. cur_code retains its value.
  - Net effect: the last valid sample at cycle t is displayed for cycles t+1 .. t+1+HOLD_CYCLES.
  - IDLE with in_valid=0: stays IDLE.
- Sweep mode (en=1, mode=1):
  - Entry from IDLE or SHOW: next cycle state=SWEEP, cur_code=0, out_valid=1, div_cnt=0, hold_cnt=0.
  - In SWEEP: div_cnt increments. When div_cnt = SWEEP_DIV-1, div_cnt returns to 0 and cur_code advances by 1, wrapping 7 to 0 (modulo 8, natural 3-bit wrap).
  - SWEEP_DIV=1: advances every cycle.
  - in_valid and code are ignored.
- mode falling 1→0 while in SWEEP:
  - If in_valid=1 that cycle, handled as the decode rule (SHOW with new code).
  - Otherwise next cycle IDLE, out_valid=0.
- mode rising during SHOW: hold is abandoned immediately; sweep starts at code 0.
- X on code while in_valid=0 must not propagate to outputs.

Decomposition:
- Package decode_3_8_pkg:
  - state enum (IDLE, SHOW, SWEEP).
  - 8-entry active-high segment pattern constant (3F,06,5B,4F,66,6D,7D,07).
  - SEG_BLANK = 8'hFF.
- Sub-module seg7_digit: 3-bit code + enable → active-low seg[7:0]. Purely combinational, reused by other board tops.

Test Plan (bench params HOLD_CYCLES=2, SWEEP_DIV=4):
1. Reset: drive rst_n=0 for 2 cycles with en=1, in_valid=1, code=5 → out_valid=0, onehot=00, seg=FF. First cycle after release → onehot=20, seg=92.
2. Single pulse: in_valid=1, code=3 for 1 cycle → onehot=08, seg=B0 for exactly 3 cycles (1+HOLD), then onehot=00, seg=FF.
3. Retrigger: code=1 then code=6 two cycles later → onehot 02 → 40. Hold restarts, so 40 persists 3 cycles after the last valid.
4. Sweep: mode=1 → onehot=01 for 4 cycles, then 02, 04 … 80, then wraps to 01. Entry cycle seg=C0.
5. Enable drop: during sweep at onehot=10, pull en=0 for 1 cycle → next cycle onehot=00, out_valid=0. Re-enable with mode=1 → sweep restarts at 01.
6. Mode exit with simultaneous valid: mode 1→0 in the same cycle as in_valid=1, code=7 → next cycle state SHOW, onehot=80, seg=F8.
